// File: rtl/cpu7_biu_arb.sv
// cpu7_biu_arb: shares the single memory port between instruction fetch (IFU) and
// load/store (LSU). It grants one requester at a time, sequences the address and data
// phases, routes the response back to the owner and discards cancelled fetches.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   ifu_req/addr/cancel              fetch request, address, redirect kill
//   ifu_ack/valid/rdata/ex           grant (comb), response pulse, data, bus error
//   lsu_req/wr/addr/wdata/wstrb      data request
//   lsu_ack/valid/rdata/ex           grant (comb), response pulse, data (0 on writes), error
//   mem_req/wr/addr/wdata/wstrb      memory request, held from latched copies until addr_ok
//   mem_addr_ok/data_ok/rdata/err    memory handshake and response
//   biu_busy                         a transaction is in progress
module cpu7_biu_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  input  logic        ifu_cancel,
  output logic        ifu_ack,
  output logic        ifu_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_ex,
  input  logic        lsu_req,
  input  logic        lsu_wr,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_ack,
  output logic        lsu_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_ex,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        biu_busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic        owner_lsu_q;
  logic        drop_q;
  logic [2:0]  starve_q;
  logic [31:0] addr_q, wdata_q;
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic        ifu_valid_q, lsu_valid_q, ifu_ex_q, lsu_ex_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q;

  logic ifu_elig, ifu_win, lsu_win, resp, starved;

  assign starved = (starve_q == 3'(STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    ifu_elig = ifu_req & ~ifu_cancel;
    ifu_win  = 1'b0;
    lsu_win  = 1'b0;
    resp     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so the combinational acks stay low while reset is held.
        if (!reset) begin
          if (ifu_elig && (!lsu_req || starved)) ifu_win = 1'b1;
          else if (lsu_req)                      lsu_win = 1'b1;
        end
        if (ifu_win || lsu_win) state_d = StAddr;
      end
      StAddr: if (mem_addr_ok) state_d = StData;
      StData: begin
        if (mem_data_ok) begin
          resp    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_lsu_q <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      wstrb_q     <= '0;
      ifu_valid_q <= 1'b0;
      lsu_valid_q <= 1'b0;
      ifu_ex_q    <= 1'b0;
      lsu_ex_q    <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      ifu_valid_q <= 1'b0;
      lsu_valid_q <= 1'b0;
      if (ifu_win || lsu_win) begin
        owner_lsu_q <= lsu_win;
        drop_q      <= 1'b0;
        addr_q      <= lsu_win ? lsu_addr : ifu_addr;
        wr_q        <= lsu_win & lsu_wr;
        wdata_q     <= lsu_win ? lsu_wdata : '0;
        wstrb_q     <= lsu_win ? lsu_wstrb : '0;
        if (ifu_win)                             starve_q <= 3'd0;
        else if (ifu_req && starve_q != 3'd7)    starve_q <= starve_q + 3'd1;
      end else if (state_q != StIdle && !owner_lsu_q && ifu_cancel) begin
        drop_q <= 1'b1;
      end
      if (resp) begin
        if (owner_lsu_q) begin
          lsu_valid_q <= 1'b1;
          lsu_rdata_q <= wr_q ? 32'd0 : mem_rdata;
          lsu_ex_q    <= mem_err;
        end else if (!(drop_q || ifu_cancel)) begin
          // A cancel in the data_ok cycle itself still kills the fetch.
          ifu_valid_q <= 1'b1;
          ifu_rdata_q <= mem_rdata;
          ifu_ex_q    <= mem_err;
        end
      end
    end
  end

  assign ifu_ack   = ifu_win;
  assign lsu_ack   = lsu_win;
  assign ifu_valid = ifu_valid_q;
  assign ifu_rdata = ifu_rdata_q;
  assign ifu_ex    = ifu_ex_q;
  assign lsu_valid = lsu_valid_q;
  assign lsu_rdata = lsu_rdata_q;
  assign lsu_ex    = lsu_ex_q;
  assign mem_req   = (state_q == StAddr);
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign biu_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_cpu7_biu_arb.sv
// Self-checking bench for cpu7_biu_arb: directed scenarios followed by random traffic.
// A transaction-level model predicts grants, memory-side request fields and busy; expected
// responses are queued and checked by an independent monitor when valid pulses appear.
module tb_cpu7_biu_arb;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_req, ifu_cancel, lsu_req, lsu_wr;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_wstrb;
  logic        mem_addr_ok, mem_data_ok, mem_err;
  logic        ifu_ack, ifu_valid, ifu_ex, lsu_ack, lsu_valid, lsu_ex;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr, biu_busy;
  logic [3:0]  mem_wstrb;

  cpu7_biu_arb #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_cancel(ifu_cancel),
    .ifu_ack(ifu_ack), .ifu_valid(ifu_valid), .ifu_rdata(ifu_rdata), .ifu_ex(ifu_ex),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_ack(lsu_ack), .lsu_valid(lsu_valid), .lsu_rdata(lsu_rdata),
    .lsu_ex(lsu_ex), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .mem_err(mem_err), .biu_busy(biu_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        ex;
    int          cyc;
  } resp_t;
  resp_t ifu_q[$];
  resp_t lsu_q[$];

  // Transaction-level model state
  bit          m_busy, m_data, m_drop, m_owner_lsu, e_wr;
  int          m_starve;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_data = 0; m_drop = 0; m_owner_lsu = 0; m_starve = 0;
  endtask

  // One clock cycle: check this cycle's outputs against the model at negedge, advance the
  // model, then retire one-shot inputs and granted requests just after the next posedge.
  task automatic tick();
    bit    exp_ia, exp_la;
    resp_t r;
    @(negedge clk);
    exp_ia = 0;
    exp_la = 0;
    if (!m_busy) begin
      if (ifu_req && !ifu_cancel && lsu_req) begin
        if (m_starve == STARVE) exp_ia = 1;
        else                    exp_la = 1;
      end else if (ifu_req && !ifu_cancel) exp_ia = 1;
      else if (lsu_req)                    exp_la = 1;
    end
    check("ack", {ifu_ack, lsu_ack}, {exp_ia, exp_la});
    check("busy", biu_busy, m_busy);
    check("mem_req", mem_req, m_busy && !m_data);
    if (m_busy && !m_data)
      check("mem_fields", {mem_addr, mem_wr, mem_wstrb, e_wr ? mem_wdata : 32'd0},
            {e_addr, e_wr, e_wstrb, e_wr ? e_wdata : 32'd0});
    if (m_busy) begin
      if (ifu_cancel && !m_owner_lsu) m_drop = 1;
      if (!m_data) begin
        if (mem_addr_ok) m_data = 1;
      end else if (mem_data_ok) begin
        r.rdata = (m_owner_lsu && e_wr) ? 32'd0 : mem_rdata;
        r.ex    = mem_err;
        r.cyc   = cyc + 1;
        if (m_owner_lsu)  lsu_q.push_back(r);
        else if (!m_drop) ifu_q.push_back(r);
        m_busy = 0;
        m_data = 0;
      end
    end else if (exp_ia || exp_la) begin
      m_busy = 1; m_data = 0; m_drop = 0; m_owner_lsu = exp_la;
      if (exp_la) begin
        e_addr = lsu_addr; e_wr = lsu_wr; e_wdata = lsu_wdata; e_wstrb = lsu_wstrb;
        if (ifu_req && m_starve < 7) m_starve++;
      end else begin
        e_addr = ifu_addr; e_wr = 0; e_wdata = 0; e_wstrb = 0;
        m_starve = 0;
      end
    end
    @(posedge clk);
    #1;
    if (exp_ia) ifu_req = 0;
    if (exp_la) lsu_req = 0;
    ifu_cancel = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_err = 0;
  endtask

  // Memory side after a grant: aw idle cycles, addr_ok, dw idle cycles, data_ok.
  task automatic serve(int aw, int dw, logic [31:0] rd, logic er);
    repeat (aw) tick();
    mem_addr_ok = 1;
    tick();
    repeat (dw) tick();
    mem_data_ok = 1; mem_rdata = rd; mem_err = er;
    tick();
  endtask

  task automatic check_all_zero(string name);
    check({name, "_req_side"}, {ifu_ack, ifu_valid, ifu_rdata, ifu_ex,
                                lsu_ack, lsu_valid, lsu_rdata, lsu_ex}, 128'd0);
    check({name, "_mem_side"}, {mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, biu_busy},
          128'd0);
  endtask

  // Response monitor, independent of stimulus
  always @(negedge clk) begin
    resp_t e;
    if (!reset) begin
      check("dual_valid", ifu_valid & lsu_valid, 1'b0);
      if (ifu_valid) begin
        if (ifu_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ifu_resp: got unexpected ifu_valid, expected none (cycle %0d)", cyc);
        end else begin
          e = ifu_q.pop_front();
          check("ifu_resp", {cyc, ifu_rdata, ifu_ex}, {e.cyc, e.rdata, e.ex});
        end
      end else if (ifu_q.size() != 0 && ifu_q[0].cyc <= cyc) begin
        e = ifu_q.pop_front();
        vectors++; miscompares++;
        $display("FAIL ifu_resp: got no ifu_valid, expected %0h at cycle %0d", e.rdata, e.cyc);
      end
      if (lsu_valid) begin
        if (lsu_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL lsu_resp: got unexpected lsu_valid, expected none (cycle %0d)", cyc);
        end else begin
          e = lsu_q.pop_front();
          check("lsu_resp", {cyc, lsu_rdata, lsu_ex}, {e.cyc, e.rdata, e.ex});
        end
      end else if (lsu_q.size() != 0 && lsu_q[0].cyc <= cyc) begin
        e = lsu_q.pop_front();
        vectors++; miscompares++;
        $display("FAIL lsu_resp: got no lsu_valid, expected %0h at cycle %0d", e.rdata, e.cyc);
      end
    end
  end

  initial begin
    bit drain;
    ifu_req = 0; ifu_cancel = 0; ifu_addr = 0;
    lsu_req = 0; lsu_wr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wstrb = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0; mem_err = 0;
    model_reset();

    // Reset: outputs zero, acks suppressed even with requests present
    #2 reset = 1;
    ifu_req = 1; lsu_req = 1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 0; ifu_req = 0; lsu_req = 0;

    // Single IFU fetch
    ifu_req = 1; ifu_addr = 32'h1C00_0000;
    tick();
    serve(0, 1, 32'h0280_0421, 1'b0);
    tick();

    // Simultaneous requests: LSU first, IFU at the next idle cycle
    ifu_req = 1; ifu_addr = 32'h1C00_0004;
    lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h100; lsu_wstrb = 0;
    tick();
    serve(1, 0, 32'hA5A5_0001, 1'b0);
    tick();
    serve(0, 0, 32'h0000_0013, 1'b0);

    // Starvation: four LSU wins, then IFU, then LSU again with the counter cleared
    for (int g = 0; g < 6; g++) begin
      if (!ifu_req) begin ifu_req = 1; ifu_addr = 32'h1C00_0100 + 32'(g * 4); end
      lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h400 + 32'(g * 4);
      tick();
      serve(0, 0, $urandom, 1'b0);
    end
    lsu_req = 0;
    if (ifu_req) begin tick(); serve(0, 0, 32'h1111_2222, 1'b0); end

    // Cancel during DATA: no ifu_valid, next fetch granted at the following idle cycle
    ifu_req = 1; ifu_addr = 32'h1C00_0200;
    tick();
    mem_addr_ok = 1;
    tick();
    ifu_cancel = 1;
    tick();
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    ifu_req = 1; ifu_addr = 32'h1C00_0300;
    tick();
    serve(0, 0, 32'h0BAD_F00D, 1'b0);

    // LSU write with bus error
    lsu_req = 1; lsu_wr = 1; lsu_addr = 32'h200; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
    tick();
    serve(1, 1, 32'hCAFE_F00D, 1'b1);
    tick();

    // Reset in DATA, then a stale data_ok while idle
    lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h300;
    tick();
    mem_addr_ok = 1;
    tick();
    ifu_req = 1; lsu_req = 1;
    reset = 1;
    #1 check_all_zero("reset_mid");
    @(posedge clk);
    #1 reset = 0; ifu_req = 0; lsu_req = 0;
    model_reset();
    mem_data_ok = 1; mem_rdata = 32'h5757_5757;
    tick();
    tick();

    // Random traffic, then drain without new requests
    drain = 0;
    for (int c = 0; c < 3200; c++) begin
      if (c == 3000) drain = 1;
      if (!drain && !ifu_req && $urandom_range(0, 2) == 0) begin
        ifu_req = 1; ifu_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!drain && !lsu_req && $urandom_range(0, 2) == 0) begin
        lsu_req = 1; lsu_wr = 1'($urandom_range(0, 1));
        lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
      end
      ifu_cancel = !drain && ($urandom_range(0, 9) == 0);
      mem_rdata = $urandom;
      mem_err = ($urandom_range(0, 5) == 0);
      if (m_busy && !m_data) begin
        mem_addr_ok = 1'($urandom_range(0, 1));
        if (!mem_addr_ok) mem_data_ok = ($urandom_range(0, 5) == 0);
      end else if (m_busy) begin
        mem_data_ok = ($urandom_range(0, 2) == 0);
      end else begin
        mem_data_ok = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    tick();
    check("queues_drained", 128'(ifu_q.size() + lsu_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
